// File: rtl/pam4_nrz_lane_sched_pkg.sv
// pam4_nrz_lane_sched_pkg: shared FSM state encoding and PAM4 symbol constants
package pam4_nrz_lane_sched_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT, HI, LO} state_t;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;
endpackage

// File: rtl/pam4_nrz_lane_sched_arb.sv
// pam4_rr_arb2: two-requester round-robin arbiter; last_grant resets to 1 so requester 0 wins first
module pam4_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic load,
  output logic winner
);
  logic last_grant;
  assign winner = (req0 && req1) ? !last_grant : req1;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b1;
    else if (load) last_grant <= winner;
endmodule

// File: rtl/pam4_nrz_lane_sched.sv
// pam4_nrz_lane_sched: round-robin frames from two PAM4 sources onto one NRZ lane,
// each frame led by an alternating 1/0 preamble, symbols sent MSB first.
module pam4_nrz_lane_sched
  import pam4_nrz_lane_sched_pkg::*;
#(
  parameter int FRAME_LEN    = 8,
  parameter int PREAMBLE_LEN = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       s0_valid,
  input  logic [1:0] s0_sym,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [1:0] s1_sym,
  output logic       s1_ready,
  output logic       nrz_out,
  output logic       nrz_valid,
  output logic       frame_start,
  output logic       grant_id,
  output logic       busy
);
  state_t           state;
  logic [CNT_W-1:0] pre_cnt, sym_cnt;
  logic [1:0]       sym_q, sel_sym;
  logic             grant, winner, start, pre_last, frame_done, rdy, sel_valid, take;
  pam4_rr_arb2 u_arb (
    .clk(clk), .reset(reset), .req0(s0_valid), .req1(s1_valid), .load(start), .winner(winner)
  );
  assign start      = state == IDLE && enable && (s0_valid || s1_valid);
  assign pre_last   = pre_cnt == CNT_W'(PREAMBLE_LEN - 1);
  assign frame_done = sym_cnt == CNT_W'(FRAME_LEN);
  // ready never looks at valid: it opens whenever the lane would otherwise run dry next cycle
  assign rdy        = (state == PRE && pre_last) || state == WAIT || (state == LO && !frame_done);
  assign sel_valid  = grant ? s1_valid : s0_valid;
  assign sel_sym    = grant ? s1_sym : s0_sym;
  assign take       = rdy && sel_valid;
  assign s0_ready    = rdy && !grant;
  assign s1_ready    = rdy && grant;
  assign nrz_valid   = state == PRE || state == HI || state == LO;
  assign nrz_out     = state == PRE ? !pre_cnt[0] : state == HI ? sym_q[1] : state == LO ? sym_q[0] : 1'b0;
  assign frame_start = state == PRE && pre_cnt == '0;
  assign busy        = state != IDLE;
  assign grant_id    = grant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      pre_cnt <= '0;
      sym_cnt <= '0;
      sym_q   <= '0;
    end else begin
      if (take) begin
        sym_q   <= sel_sym;
        sym_cnt <= sym_cnt + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          grant   <= winner;
          pre_cnt <= '0;
          sym_cnt <= '0;
          state   <= PRE;
        end
        PRE: begin
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_last) state <= take ? HI : WAIT;
        end
        WAIT: if (take) state <= HI;
        HI: state <= LO;
        LO: state <= frame_done ? IDLE : take ? HI : WAIT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pam4_nrz_lane_sched.sv
// tb_pam4_nrz_lane_sched: two DUTs (8/4 and 1/2 framing) on shared random stimulus,
// each checked against a lane-level model of pending NRZ bits.
module tb_pam4_nrz_lane_sched;
  logic clk = 1'b0;
  logic reset, enable, s0_valid, s1_valid;
  logic [1:0] s0_sym, s1_sym;
  logic s0_ready[2], s1_ready[2], nrz_out[2], nrz_valid[2], frame_start[2], grant_id[2], busy[2];
  int n_chk = 0, n_fail = 0;
  int fl[2] = '{8, 1};
  int pl[2] = '{4, 2};
  logic [1:0] pat[4] = '{2'b11, 2'b01, 2'b10, 2'b00};
  bit in_frame[2], owner[2], last[2];
  int taken[2], pend[2];
  logic [15:0] pb[2], pf[2];
  always #5 clk = ~clk;
  pam4_nrz_lane_sched dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .s0_valid(s0_valid), .s0_sym(s0_sym), .s0_ready(s0_ready[0]),
    .s1_valid(s1_valid), .s1_sym(s1_sym), .s1_ready(s1_ready[0]),
    .nrz_out(nrz_out[0]), .nrz_valid(nrz_valid[0]), .frame_start(frame_start[0]),
    .grant_id(grant_id[0]), .busy(busy[0])
  );
  pam4_nrz_lane_sched #(.FRAME_LEN(1), .PREAMBLE_LEN(2), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .s0_valid(s0_valid), .s0_sym(s0_sym), .s0_ready(s0_ready[1]),
    .s1_valid(s1_valid), .s1_sym(s1_sym), .s1_ready(s1_ready[1]),
    .nrz_out(nrz_out[1]), .nrz_valid(nrz_valid[1]), .frame_start(frame_start[1]),
    .grant_id(grant_id[1]), .busy(busy[1])
  );
  task automatic chk(input string tag, input int k, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got %b expected %b", tag, k, $time, got, exp);
    end
  endtask
  task automatic mreset;
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 0; owner[k] = 0; last[k] = 1;
      taken[k] = 0; pend[k] = 0; pb[k] = '0; pf[k] = '0;
    end
  endtask
  // lane model: a list of bits still owed to the lane; a source is asked for a symbol
  // exactly when that list would be empty after this cycle and the frame still needs symbols
  task automatic model(input int k);
    bit ev, eb, ef, rdy, v, w;
    logic [1:0] sym;
    ev  = pend[k] > 0;
    eb  = ev && pb[k][0];
    ef  = ev && pf[k][0];
    rdy = in_frame[k] && taken[k] < fl[k] && pend[k] <= 1;
    chk("nrz_valid", k, nrz_valid[k], ev);
    chk("nrz_out", k, nrz_out[k], eb);
    chk("frame_start", k, frame_start[k], ef);
    chk("busy", k, busy[k], in_frame[k]);
    chk("s0_ready", k, s0_ready[k], rdy && !owner[k]);
    chk("s1_ready", k, s1_ready[k], rdy && owner[k]);
    chk("grant_id", k, grant_id[k], owner[k]);
    if (ev) begin
      pb[k] = pb[k] >> 1; pf[k] = pf[k] >> 1; pend[k]--;
    end
    v = owner[k] ? s1_valid : s0_valid;
    if (rdy && v) begin
      sym = owner[k] ? s1_sym : s0_sym;
      pb[k][pend[k]] = sym[1];
      pb[k][pend[k]+1] = sym[0];
      pend[k] += 2;
      taken[k]++;
    end else if (in_frame[k] && taken[k] == fl[k] && pend[k] == 0) begin
      in_frame[k] = 0;
    end else if (!in_frame[k] && enable && (s0_valid || s1_valid)) begin
      w = (s0_valid && s1_valid) ? !last[k] : s1_valid;
      owner[k] = w; last[k] = w; in_frame[k] = 1; taken[k] = 0;
      for (int i = 0; i < pl[k]; i++) begin
        pb[k][i] = (i % 2 == 0);
        pf[k][i] = (i == 0);
      end
      pend[k] = pl[k];
    end
  endtask
  task automatic cyc(input bit en, input bit v0, input logic [1:0] d0, input bit v1, input logic [1:0] d1);
    @(posedge clk);
    #1;
    enable = en; s0_valid = v0; s0_sym = d0; s1_valid = v1; s1_sym = d1;
    @(negedge clk);
    model(0);
    model(1);
  endtask
  task automatic rst_mid;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_nrz_valid", k, nrz_valid[k], 1'b0);
      chk("rst_nrz_out", k, nrz_out[k], 1'b0);
      chk("rst_frame_start", k, frame_start[k], 1'b0);
      chk("rst_busy", k, busy[k], 1'b0);
      chk("rst_s0_ready", k, s0_ready[k], 1'b0);
      chk("rst_s1_ready", k, s1_ready[k], 1'b0);
      chk("rst_grant_id", k, grant_id[k], 1'b0);
    end
    enable = 0; s0_valid = 0; s1_valid = 0;
    mreset;
    @(negedge clk);
    reset = 1'b0;
  endtask
  function automatic logic [1:0] rs();
    return 2'($urandom_range(0, 3));
  endfunction
  initial begin
    reset = 1'b1; enable = 0; s0_valid = 0; s1_valid = 0; s0_sym = 0; s1_sym = 0;
    mreset;
    repeat (2) @(negedge clk);
    model(0);
    model(1);
    reset = 1'b0;
    // source 0 alone with the 11,01,10,00 pattern
    for (int i = 0; i < 24; i++) cyc(1, 1, pat[taken[0] % 4], 0, 2'b00);
    // both requesting: frames alternate owners
    for (int i = 0; i < 70; i++) cyc(1, 1, rs(), 1, rs());
    // drain to idle, then source 1 alone with a 3-cycle valid gap after its 2nd symbol
    for (int i = 0; i < 40 && in_frame[0]; i++) cyc(0, 1, rs(), 1, rs());
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 2'b00, 1, rs());
      if (in_frame[0] && taken[0] == 2) break;
    end
    repeat (3) cyc(1, 0, 2'b00, 0, rs());
    for (int i = 0; i < 40 && in_frame[0]; i++) cyc(0, 0, 2'b00, 1, rs());
    // reset during the 5th symbol's HI cycle, then both request: source 0 must win
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, rs(), 1, rs());
      if (in_frame[0] && taken[0] == 5) break;
    end
    rst_mid;
    for (int i = 0; i < 30; i++) cyc(1, 1, rs(), 1, rs());
    // enable drops mid-frame: the frame completes, no new one starts
    for (int i = 0; i < 10 && !in_frame[0]; i++) cyc(1, 1, rs(), 1, rs());
    for (int i = 0; i < 40; i++) cyc(0, 1, rs(), 1, rs());
    // random traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst_mid;
      else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, rs(), $urandom_range(0, 3) != 0, rs());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
